// File: rtl/ds_seq_pkg.sv
// Shared types and default sizing for the delta-sigma sample sequencer.
// Optional feature macro used by the top level: DS_SEQ_UNDERFLOW_CNT_EN.
package ds_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } ds_seq_state_t;

    localparam int DS_SEQ_SAMPLE_BITS = 16;
    localparam int DS_SEQ_FIFO_DEPTH  = 4;
    localparam int DS_SEQ_DIV_BITS    = 12;

endpackage

// File: rtl/ds_sample_fifo.sv
// Small power-of-two sample FIFO with wrapping pointers and an occupancy counter.
// Push is ignored when full and pop is ignored when empty.
module ds_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_q == (AW+1)'(DEPTH));
    assign empty     = (level_q == (AW+1)'(0));
    assign level     = level_q;
    assign head      = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ds_sample_sequencer.sv
// Paces buffered host samples into the delta-sigma modulator, one per divider tick.
// Define DS_SEQ_UNDERFLOW_CNT_EN to add the saturating underflow_count output.
module ds_sample_sequencer
    import ds_seq_pkg::*;
#(
    parameter int SAMPLE_BITS = DS_SEQ_SAMPLE_BITS,
    parameter int FIFO_DEPTH  = DS_SEQ_FIFO_DEPTH,
    parameter int DIV_BITS    = DS_SEQ_DIV_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [DIV_BITS-1:0]             divider,
    input  logic [SAMPLE_BITS-1:0]          in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [SAMPLE_BITS-1:0]          sample_out,
    output logic                            sample_strobe,
    output logic                            underflow
`ifdef DS_SEQ_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]                      underflow_count
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    ds_seq_state_t          state_q;
    ds_seq_state_t          state_d;
    logic [DIV_BITS-1:0]    cnt_q;
    logic [DIV_BITS-1:0]    cnt_d;
    logic [SAMPLE_BITS-1:0] sample_out_q;
    logic                   strobe_q;
    logic                   underflow_q;

    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [LW-1:0]          fifo_level_s;
    logic [SAMPLE_BITS-1:0] fifo_head_s;
    logic                   push_s;
    logic                   tick_s;
    logic                   pop_s;
    logic                   starve_s;

    assign push_s   = in_valid && !fifo_full_s;
    assign tick_s   = enable && (state_q == ST_RUN) && (cnt_q == {DIV_BITS{1'b0}});
    assign pop_s    = tick_s && !fifo_empty_s;
    assign starve_s = tick_s && fifo_empty_s;

    ds_sample_fifo #(
        .WIDTH (SAMPLE_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (in_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    // Next state and tick counter; dropping enable overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    if (fifo_level_s >= LW'(FIFO_DEPTH / 2)) begin
                        state_d = ST_RUN;
                        cnt_d   = divider;
                    end else begin
                        state_d = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        cnt_d   = divider;
                        state_d = fifo_empty_s ? ST_PRIME : ST_RUN;
                    end else begin
                        cnt_d = cnt_q - DIV_BITS'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, tick counter and registered modulator-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {DIV_BITS{1'b0}};
            sample_out_q <= {SAMPLE_BITS{1'b0}};
            strobe_q     <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strobe_q    <= pop_s;
            underflow_q <= starve_s;
            if (pop_s) begin
                sample_out_q <= fifo_head_s;
            end
        end
    end

    assign in_ready      = !fifo_full_s;
    assign fifo_level    = fifo_level_s;
    assign sample_out    = sample_out_q;
    assign sample_strobe = strobe_q;
    assign underflow     = underflow_q;

`ifdef DS_SEQ_UNDERFLOW_CNT_EN
    logic [7:0] uf_cnt_q;

    // Starved-tick counter, saturating at 255; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uf_cnt_q <= 8'd0;
        end else if (starve_s && (uf_cnt_q != 8'hFF)) begin
            uf_cnt_q <= uf_cnt_q + 8'd1;
        end else begin
            uf_cnt_q <= uf_cnt_q;
        end
    end

    assign underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_ds_sample_sequencer.sv
// Scoreboard bench for ds_sample_sequencer: stimulus queues expected samples,
// a negedge monitor compares each strobe/underflow against the queue.
module tb_ds_sample_sequencer;

    localparam int SB = 16;
    localparam int DB = 12;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DB-1:0] divider;
    logic [SB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] fifo_level;
    logic [SB-1:0] sample_out;
    logic          sample_strobe;
    logic          underflow;
`ifdef DS_SEQ_UNDERFLOW_CNT_EN
    logic [7:0]    underflow_count;
`endif

    ds_sample_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .divider       (divider),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fifo_level    (fifo_level),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .underflow     (underflow)
`ifdef DS_SEQ_UNDERFLOW_CNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SB-1:0] data;
        int            gap;
    } exp_t;

    exp_t          exp_q[$];
    int            checks     = 0;
    int            errors     = 0;
    int            cyc        = 0;
    int            last_cyc   = 0;
    int            strobe_cnt = 0;
    int            uf_expect  = 0;
    int            uf_model   = 0;
    logic [SB-1:0] last_val   = 16'h0000;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_sample(input logic [SB-1:0] d, input int gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic expect_underflow();
        uf_expect++;
        uf_model++;
    endtask

    // Leaves in_valid high so back-to-back calls stream without a gap.
    task automatic push(input logic [SB-1:0] d);
        logic acc;
        int   n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: data %h not accepted, required acceptance within 200 cycles", d);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || uf_expect != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_pending"}, exp_q.size() + uf_expect, 0);
        exp_q.delete();
        uf_expect = 0;
    endtask

    task automatic wait_strobe(input int budget);
        int s0;
        int n;
        s0 = strobe_cnt;
        n  = 0;
        while (strobe_cnt == s0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("strobe_wait", int'(strobe_cnt != s0), 1);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every strobe must match the queue head; every underflow must be expected.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (sample_strobe) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got sample_out=%h, required no strobe", sample_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_data", int'(sample_out), int'(e.data));
                    if (e.gap != 0) begin
                        chk("strobe_gap", cyc - last_cyc, e.gap);
                    end
                    last_val = e.data;
                end
                last_cyc = cyc;
            end
            if (underflow) begin
                chk("underflow_expected", int'(uf_expect > 0), 1);
                chk("underflow_hold", int'(sample_out), int'(last_val));
                if (uf_expect > 0) begin
                    uf_expect--;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        reset    = 1'b1;
        enable   = 1'b0;
        divider  = 12'd0;
        in_data  = 16'h0000;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_strobe", int'(sample_strobe), 0);
        chk("rst_underflow", int'(underflow), 0);
`ifdef DS_SEQ_UNDERFLOW_CNT_EN
        chk("rst_uf_count", int'(underflow_count), 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Enabled with no data: stays priming, never strobes.
        divider = 12'd3;
        enable  = 1'b1;
        s0 = strobe_cnt;
        repeat (100) @(posedge clk);
        #1;
        chk("prime_no_strobe", strobe_cnt - s0, 0);
        chk("prime_level", int'(fifo_level), 0);

        // Pacing at divider 3, then starvation on the third tick.
        expect_sample(16'h1111, 0);
        expect_sample(16'h2222, 4);
        expect_underflow();
        push(16'h1111);
        push(16'h2222);
        in_valid = 1'b0;
        wait_drain("pace", 100);
        chk("starve_hold", int'(sample_out), 16'h2222);

        // Two new pushes restart output.
        expect_sample(16'h3333, 0);
        expect_sample(16'h4444, 4);
        expect_underflow();
        push(16'h3333);
        push(16'h4444);
        in_valid = 1'b0;
        wait_drain("restart", 100);

        // Divider 7 -> 1 between ticks: current period stays 8, then 2.
        divider = 12'd7;
        expect_sample(16'hA001, 0);
        expect_sample(16'hA002, 8);
        expect_sample(16'hA003, 2);
        expect_sample(16'hA004, 2);
        expect_sample(16'hA005, 2);
        expect_underflow();
        push(16'hA001);
        push(16'hA002);
        push(16'hA003);
        push(16'hA004);
        in_valid = 1'b0;
        wait_strobe(50);
        divider = 12'd1;
        push(16'hA005);
        in_valid = 1'b0;
        wait_drain("div_change", 100);

        // Full FIFO with in_valid held: no push while full, stream stays ordered.
        enable  = 1'b0;
        divider = 12'd0;
        @(posedge clk);
        #1;
        push(16'hB001);
        push(16'hB002);
        push(16'hB003);
        push(16'hB004);
        in_data = 16'hB005;
        repeat (2) @(posedge clk);
        #1;
        chk("full_level", int'(fifo_level), 4);
        chk("full_in_ready", int'(in_ready), 0);
        chk("idle_hold", int'(sample_out), 16'hA005);
        expect_sample(16'hB001, 0);
        for (int i = 2; i <= 12; i++) begin
            expect_sample(16'hB000 + 16'(i), 1);
        end
        expect_underflow();
        enable = 1'b1;
        for (int i = 5; i <= 12; i++) begin
            push(16'hB000 + 16'(i));
        end
        in_valid = 1'b0;
        wait_drain("full_stream", 100);

        // Disable in RUN: back to IDLE, FIFO contents kept.
        divider = 12'd7;
        push(16'hC001);
        push(16'hC002);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        s0 = strobe_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("disable_no_strobe", strobe_cnt - s0, 0);
        chk("disable_level", int'(fifo_level), 2);
        chk("disable_hold", int'(sample_out), 16'hB00C);
        expect_sample(16'hC001, 0);
        expect_sample(16'hC002, 8);
        expect_underflow();
        enable = 1'b1;
        wait_drain("reenable", 100);

`ifdef DS_SEQ_UNDERFLOW_CNT_EN
        chk("uf_count_mid", int'(underflow_count), uf_model);
        divider = 12'd0;
        for (int i = 0; i < 300; i++) begin
            expect_sample(16'(2 * i), 0);
            expect_sample(16'(2 * i + 1), 1);
            expect_underflow();
            push(16'(2 * i));
            push(16'(2 * i + 1));
            in_valid = 1'b0;
            wait_drain("uf_loop", 50);
        end
        chk("uf_count_sat", int'(underflow_count), 255);
`endif

        // Asynchronous reset mid-run clears everything before the next edge.
        divider = 12'd3;
        expect_sample(16'hD001, 0);
        expect_sample(16'hD002, 4);
        push(16'hD001);
        push(16'hD002);
        in_valid = 1'b0;
        wait_strobe(50);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_level", int'(fifo_level), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_sample_out", int'(sample_out), 0);
        chk("arst_strobe", int'(sample_strobe), 0);
        chk("arst_underflow", int'(underflow), 0);
`ifdef DS_SEQ_UNDERFLOW_CNT_EN
        chk("arst_uf_count", int'(underflow_count), 0);
`endif
        exp_q.delete();
        uf_expect = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
